dual_instr_queue: RTL and testbench

- Dual-entry-per-cycle instruction queue on the receiving end of the two-wide fetch interface (instr1, instr2, finish).
- Accepts 0, 1 or 2 instructions per cycle from fetch in program order and buffers them in a circular store.
- Presents the two oldest entries to decode/dispatch, which pops 0, 1 or 2 per cycle.
- Tracks end-of-program: signals drained once fetch has reported finish and every buffered instruction has been consumed.

---
 rtl/dual_instr_queue_if.sv | 26 ++
 rtl/dual_instr_queue.sv | 90 +++++++++
 tb/tb_dual_instr_queue.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_instr_queue_if.sv
// rtl/dual_instr_queue_if.sv - fetch-side push and dispatch-side pop signals of the instruction queue
interface dual_instr_queue_if #(
    parameter int IW = 32
);
    logic          in_valid1;
    logic          in_valid2;
    logic [IW-1:0] in_instr1;
    logic [IW-1:0] in_instr2;
    logic          in_finish;
    logic          in_ready;
    logic [IW-1:0] out_instr1;
    logic [IW-1:0] out_instr2;
    logic          out_valid1;
    logic          out_valid2;
    logic [1:0]    pop;

    modport master (
        output in_valid1, in_valid2, in_instr1, in_instr2, in_finish, pop,
        input  in_ready, out_instr1, out_instr2, out_valid1, out_valid2
    );

    modport slave (
        input  in_valid1, in_valid2, in_instr1, in_instr2, in_finish, pop,
        output in_ready, out_instr1, out_instr2, out_valid1, out_valid2
    );
endinterface

// File: rtl/dual_instr_queue.sv
// rtl/dual_instr_queue.sv - two-wide circular instruction queue with end-of-program drain tracking
module dual_instr_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    dual_instr_queue_if.slave      q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW-1:0] head_p1, tail_p1;
    state_t        state;
    logic [1:0]    push_n;
    logic [1:0]    pop_req;
    logic [1:0]    pop_n;
    logic [CW-1:0] count_next;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    // Readiness looks only at registered occupancy so fetch never depends on this cycle's pop.
    assign q.in_ready = (count <= READY_MAX);

    always_comb begin
        push_n = 2'd0;
        if (q.in_ready && q.in_valid1) begin
            push_n = q.in_valid2 ? 2'd2 : 2'd1;
        end
    end

    assign pop_req    = q.pop[1] ? 2'd2 : {1'b0, q.pop[0]};
    assign pop_n      = (count < CW'(pop_req)) ? count[1:0] : pop_req;
    assign count_next = count + CW'(push_n) - CW'(pop_n);

    assign q.out_valid1 = (count >= CW'(1));
    assign q.out_valid2 = (count >= CW'(2));
    assign q.out_instr1 = q.out_valid1 ? mem[head]    : '0;
    assign q.out_instr2 = q.out_valid2 ? mem[head_p1] : '0;

    assign drained = (state == DONE);

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_n != 2'd0) mem[tail]    <= q.in_instr1;
            if (push_n == 2'd2) mem[tail_p1] <= q.in_instr2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count_next;
            case (state)
                RUN: begin
                    if (q.in_finish) begin
                        state <= (count_next == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == '0) state <= DONE;
                end
                DONE: begin
                    if (push_n != 2'd0) state <= DRAIN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_instr_queue.sv
// tb/tb_dual_instr_queue.sv - scoreboard bench for dual_instr_queue
module tb_dual_instr_queue;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] count;
    logic       drained;

    dual_instr_queue_if #(.IW(32)) q ();

    dual_instr_queue #(.DEPTH(8), .IW(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .q(q),
        .count(count),
        .drained(drained)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    int m_state;
    int n_tests = 0;
    int n_fail  = 0;

    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

    task automatic idle();
        q.in_valid1 = 1'b0;
        q.in_valid2 = 1'b0;
        q.in_instr1 = 32'h0;
        q.in_instr2 = 32'h0;
        q.in_finish = 1'b0;
        q.pop       = 2'd0;
        flush       = 1'b0;
    endtask

    // Advance the reference model with the currently driven inputs, then clock the DUT.
    task automatic cycle();
        int pn, rq, qn, nsz;
        if (flush) begin
            exp_q.delete();
            m_state = M_RUN;
        end else begin
            pn = ((exp_q.size() <= 6) && q.in_valid1) ? (q.in_valid2 ? 2 : 1) : 0;
            rq = (q.pop >= 2) ? 2 : int'(q.pop);
            qn = (rq < exp_q.size()) ? rq : exp_q.size();
            for (int k = 0; k < qn; k++) void'(exp_q.pop_front());
            if (pn >= 1) exp_q.push_back(q.in_instr1);
            if (pn == 2) exp_q.push_back(q.in_instr2);
            nsz = exp_q.size();
            case (m_state)
                M_RUN:   if (q.in_finish) m_state = (nsz == 0) ? M_DONE : M_DRAIN;
                M_DRAIN: if (nsz == 0) m_state = M_DONE;
                default: if (pn != 0) m_state = M_DRAIN;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        exp_q.delete();
        m_state = M_RUN;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (q.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", q.in_ready); end
        n_tests++; if (q.out_valid1 !== 1'b0 || q.out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b%b expected 00", q.out_valid1, q.out_valid2); end
        n_tests++; if (drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained: got %b expected 0", drained); end
        n_tests++; if (q.out_instr1 !== 32'h0 || q.out_instr2 !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h %h expected 0 0", q.out_instr1, q.out_instr2); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            q.in_valid1 = 1'b1;
            q.in_valid2 = 1'b1;
            q.in_instr1 = 32'hA000_0000 + 32'(2 * i);
            q.in_instr2 = 32'hA000_0000 + 32'(2 * i + 1);
            q.pop       = 2'd0;
            cycle();
            n_tests++; if (count !== 4'(2 * (i + 1))) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", count, 2 * (i + 1)); end
            n_tests++; if (q.in_ready !== (exp_q.size() <= 6)) begin n_fail++; $display("FAIL fill_in_ready: got %b at count %0d", q.in_ready, count); end
        end
        idle();
        n_tests++; if (q.out_instr1 !== 32'hA000_0000) begin n_fail++; $display("FAIL fill_head: got %h expected a0000000", q.out_instr1); end
        n_tests++; if (q.out_instr2 !== 32'hA000_0001) begin n_fail++; $display("FAIL fill_head2: got %h expected a0000001", q.out_instr2); end
    endtask

    task automatic test_full_pop();
        int guard;
        q.in_valid1 = 1'b1;
        q.in_valid2 = 1'b1;
        q.in_instr1 = 32'hC000_0000;
        q.in_instr2 = 32'hC000_0001;
        q.pop       = 2'd2;
        n_tests++; if (q.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", q.in_ready); end
        cycle();
        n_tests++; if (count !== 4'd6) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 6", count); end
        n_tests++; if (q.out_instr1 !== 32'hA000_0002) begin n_fail++; $display("FAIL full_drop_head: got %h expected a0000002", q.out_instr1); end
        n_tests++; if (q.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_retry_ready: got %b expected 1", q.in_ready); end
        cycle();
        n_tests++; if (count !== 4'd6) begin n_fail++; $display("FAIL full_accept_count: got %0d expected 6", count); end
        idle();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            q.pop = 2'd2;
            n_tests++; if (q.out_instr1 !== exp_q[0]) begin n_fail++; $display("FAIL drain_out1: got %h expected %h", q.out_instr1, exp_q[0]); end
            n_tests++; if (q.out_valid2 !== (exp_q.size() >= 2)) begin n_fail++; $display("FAIL drain_valid2: got %b", q.out_valid2); end
            if (exp_q.size() >= 2) begin
                n_tests++; if (q.out_instr2 !== exp_q[1]) begin n_fail++; $display("FAIL drain_out2: got %h expected %h", q.out_instr2, exp_q[1]); end
            end
            cycle();
            guard++;
        end
        idle();
        n_tests++; if (guard >= 20 || count !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got count %0d after %0d cycles expected 0", count, guard); end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int i = 0; i < 7; i++) begin
            q.in_valid1 = 1'b1;
            q.in_valid2 = 1'b0;
            q.in_instr1 = 32'hD000_0000 + 32'(i);
            q.pop       = (i > 0) ? 2'd1 : 2'd0;
            cycle();
        end
        idle();
        q.pop = 2'd1;
        cycle();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_pre_count: got %0d expected 0", count); end
        idle();
        q.in_valid1 = 1'b1;
        q.in_valid2 = 1'b1;
        q.in_instr1 = 32'hB000_0000;
        q.in_instr2 = 32'hB000_0001;
        cycle();
        n_tests++; if (q.out_instr1 !== 32'hB000_0000 || q.out_instr1 !== exp_q[0]) begin n_fail++; $display("FAIL wrap_b0: got %h expected b0000000", q.out_instr1); end
        n_tests++; if (q.out_instr2 !== 32'hB000_0001 || q.out_instr2 !== exp_q[1]) begin n_fail++; $display("FAIL wrap_b1: got %h expected b0000001", q.out_instr2); end
        q.in_valid2 = 1'b0;
        q.in_instr1 = 32'hB000_0002;
        q.pop       = 2'd2;
        cycle();
        idle();
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", count); end
        n_tests++; if (q.out_instr1 !== 32'hB000_0002) begin n_fail++; $display("FAIL wrap_head1: got %h expected b0000002", q.out_instr1); end
    endtask

    task automatic test_valid2_only();
        idle();
        q.in_valid2 = 1'b1;
        q.in_instr2 = 32'hEEEE_EEEE;
        cycle();
        idle();
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL v2only_count: got %0d expected 1", count); end
        n_tests++; if (q.out_instr1 !== exp_q[0]) begin n_fail++; $display("FAIL v2only_head: got %h expected %h", q.out_instr1, exp_q[0]); end
        q.pop = 2'd2;
        cycle();
        idle();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL underpop_count: got %0d expected 0", count); end
        n_tests++; if (q.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL underpop_valid1: got %b expected 0", q.out_valid1); end
    endtask

    task automatic test_finish();
        do_flush();
        q.in_valid1 = 1'b1;
        q.in_valid2 = 1'b1;
        q.in_instr1 = 32'hF000_0000;
        q.in_instr2 = 32'hF000_0001;
        q.in_finish = 1'b1;
        cycle();
        idle();
        n_tests++; if (count !== 4'd2 || drained !== 1'b0) begin n_fail++; $display("FAIL finish_push: got count %0d drained %b expected 2 0", count, drained); end
        q.pop = 2'd2;
        cycle();
        n_tests++; if (drained !== 1'b1 || m_state != M_DONE) begin n_fail++; $display("FAIL finish_drained: got %b expected 1", drained); end
        q.pop = 2'd3;
        cycle();
        idle();
        cycle();
        n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL finish_hold: got %b expected 1", drained); end
        q.in_valid1 = 1'b1;
        q.in_instr1 = 32'hF000_0002;
        cycle();
        idle();
        n_tests++; if (drained !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL done_push: got drained %b count %0d expected 0 1", drained, count); end
        q.pop = 2'd1;
        cycle();
        idle();
        n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL redrain: got %b expected 1", drained); end
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            q.in_valid1 = 1'b1;
            q.in_valid2 = (i < 2);
            q.in_instr1 = 32'h5000_0000 + 32'(2 * i);
            q.in_instr2 = 32'h5000_0001 + 32'(2 * i);
            q.in_finish = (i == 2);
            cycle();
        end
        idle();
        n_tests++; if (count !== 4'd5 || drained !== 1'b0) begin n_fail++; $display("FAIL flush_setup: got count %0d drained %b expected 5 0", count, drained); end
        flush       = 1'b1;
        q.pop       = 2'd2;
        q.in_valid1 = 1'b1;
        q.in_valid2 = 1'b1;
        q.in_finish = 1'b1;
        cycle();
        idle();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_tests++; if (drained !== 1'b0 || q.in_ready !== 1'b1 || q.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_flags: got drained %b in_ready %b valid1 %b expected 0 1 0", drained, q.in_ready, q.out_valid1); end
        q.pop = 2'd2;
        cycle();
        idle();
        n_tests++; if (drained !== 1'b0 || m_state != M_RUN) begin n_fail++; $display("FAIL flush_state_run: got drained %b expected 0", drained); end
        q.in_valid1 = 1'b1;
        q.in_valid2 = 1'b1;
        q.in_finish = 1'b1;
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_state = M_RUN;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", count); end
        n_tests++; if (drained !== 1'b0 || q.in_ready !== 1'b1 || q.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got drained %b in_ready %b valid1 %b expected 0 1 0", drained, q.in_ready, q.out_valid1); end
        rst_n = 1'b1;
        cycle();
        n_tests++; if (count !== 4'd0 || drained !== 1'b0) begin n_fail++; $display("FAIL postreset: got count %0d drained %b expected 0 0", count, drained); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_full_pop();
        test_wrap();
        test_valid2_only();
        test_finish();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
